// File: rtl/bignum_mac_400bit.sv
// Byte-serial multiply-accumulate: product = multiplicand * multiplier + addend, LSB byte first.
// Optional build macro BIGNUM_MAC_ZERO_SKIP_EN: a zero multiplier finishes in one cycle.
module bignum_mac_400bit #(
  parameter int NBYTES = 50
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [8*NBYTES-1:0]   multiplicand,
  input  logic [7:0]            multiplier,
  input  logic [7:0]            addend,
  output logic [8*NBYTES+7:0]   product,
  output logic                  busy,
  output logic                  done
);

  localparam int AW = 8 * NBYTES;
  localparam int PW = AW + 8;
  localparam int IW = (NBYTES > 1) ? $clog2(NBYTES) : 1;

  typedef enum logic {IDLE, RUN} state_e;

  // Handshake: start is taken only in IDLE; done is a one-cycle pulse and product
  // is valid from done until the next accepted start (busy=0 also qualifies it).
  state_e          state_q, state_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [7:0]      carry_q, carry_d;
  logic [AW-1:0]   a_q, a_d;
  logic [7:0]      m_q, m_d;
  logic [PW-1:0]   product_q, product_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;

  logic [7:0]      a_byte;
  logic [15:0]     t;
  logic            skip;

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    carry_d   = carry_q;
    a_d       = a_q;
    m_d       = m_q;
    product_d = product_q;
    busy_d    = busy_q;
    done_d    = 1'b0;

    a_byte = a_q[8*int'(idx_q) +: 8];
    // 255*255 + 255 = 65280 fits in 16 bits, so the carry is never lost.
    t = 16'(a_byte) * 16'(m_q) + 16'(carry_q);
`ifdef BIGNUM_MAC_ZERO_SKIP_EN
    skip = (m_q == 8'd0);
`else
    skip = 1'b0;
`endif

    case (state_q)
      IDLE: begin
        if (start) begin
          a_d       = multiplicand;
          m_d       = multiplier;
          product_d = '0;
          carry_d   = addend;
          idx_d     = '0;
          busy_d    = 1'b1;
          state_d   = RUN;
        end
      end
      RUN: begin
        if (skip) begin
          // Only reachable on the first RUN cycle, where carry still holds the addend.
          product_d = PW'(carry_q);
          busy_d    = 1'b0;
          done_d    = 1'b1;
          state_d   = IDLE;
        end else begin
          product_d[8*int'(idx_q) +: 8] = t[7:0];
          carry_d = t[15:8];
          if (idx_q == IW'(NBYTES - 1)) begin
            product_d[PW-1 -: 8] = t[15:8];
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      carry_q   <= '0;
      a_q       <= '0;
      m_q       <= '0;
      product_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      carry_q   <= carry_d;
      a_q       <= a_d;
      m_q       <= m_d;
      product_q <= product_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign product = product_q;
  assign busy    = busy_q;
  assign done    = done_q;

endmodule

// File: tb/tb_bignum_mac_400bit.sv
// Scoreboard bench for bignum_mac_400bit: directed vectors, divider round trips, reset and restart cases.
module tb_bignum_mac_400bit;

  localparam int NBYTES = 50;
  localparam int AW = 8 * NBYTES;
  localparam int PW = AW + 8;
`ifdef BIGNUM_MAC_ZERO_SKIP_EN
  localparam int ZERO_LAT = 1;
`else
  localparam int ZERO_LAT = NBYTES;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [AW-1:0] multiplicand;
  logic [7:0]    multiplier;
  logic [7:0]    addend;
  logic [PW-1:0] product;
  logic          busy;
  logic          done;

  logic [PW-1:0] exp_q[$];
  logic [PW-1:0] mon_exp;
  int            checks = 0;
  int            errors = 0;

  bignum_mac_400bit #(.NBYTES(NBYTES)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
    .addend       (addend),
    .product      (product),
    .busy         (busy),
    .done         (done)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [PW-1:0] act, input logic [PW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [AW-1:0] rand400();
    logic [AW-1:0] r;
    r = '0;
    for (int i = 0; i < 13; i++) r = {r[AW-33:0], 32'($urandom())};
    return r;
  endfunction

  // monitor: every done pulse pops one expected product
  always @(negedge clk) begin
    if (!rst && done === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done=1 expected no pending result");
      end else begin
        mon_exp = exp_q.pop_front();
        check("product", product, mon_exp);
      end
    end
  end

  // driver: call at a negedge; start is sampled at the following posedge (E0)
  task automatic start_op(input logic [AW-1:0] mc, input logic [7:0] m,
                          input logic [7:0] a, input logic [PW-1:0] exp);
    multiplicand = mc;
    multiplier   = m;
    addend       = a;
    start        = 1'b1;
    exp_q.push_back(exp);
    @(negedge clk);
    start        = 1'b0;
    multiplicand = rand400();
    multiplier   = 8'($urandom_range(0, 255));
    addend       = 8'($urandom_range(0, 255));
    check("busy_after_accept", PW'(busy), PW'(1));
    check("done_after_accept", PW'(done), PW'(0));
  endtask

  // Called at the negedge after E0; returns at the negedge where done is seen.
  task automatic wait_done(input int exp_lat);
    int k;
    int busy_n;
    k = 0;
    busy_n = 0;
    while (k <= 200 && done !== 1'b1) begin
      if (busy === 1'b1) busy_n++;
      @(negedge clk);
      k++;
    end
    check("latency", PW'(k), PW'(exp_lat));
    check("busy_cycles", PW'(busy_n), PW'(exp_lat));
    check("busy_low_at_done", PW'(busy), PW'(0));
  endtask

  task automatic check_done_drops();
    @(negedge clk);
    check("done_one_cycle", PW'(done), PW'(0));
  endtask

  initial begin
    logic [AW-1:0] div;
    logic [AW-1:0] q;
    logic [7:0]    r;
    logic [7:0]    dv [4];
    int            n_done;

    dv[0] = 8'd7; dv[1] = 8'd1; dv[2] = 8'h80; dv[3] = 8'hFF;
    rst = 1'b1;
    start = 1'b0;
    multiplicand = '0;
    multiplier = '0;
    addend = '0;
    repeat (2) @(negedge clk);
    check("reset_product", product, '0);
    check("reset_busy", PW'(busy), PW'(0));
    check("reset_done", PW'(done), PW'(0));
    rst = 1'b0;
    @(negedge clk);

    // minimal operands
    start_op(400'd1, 8'd1, 8'd0, 408'd1);
    wait_done(NBYTES);
    check_done_drops();

    // full carry ripple: (2^400-1)*255 + 255 = 255 * 2^400
    start_op({AW{1'b1}}, 8'hFF, 8'hFF, {8'hFF, {AW{1'b0}}});
    wait_done(NBYTES);
    check_done_drops();

    // round trips against a divider model
    for (int i = 0; i < 4; i++) begin
      div = rand400();
      q = div / AW'(dv[i]);
      r = 8'(div % AW'(dv[i]));
      start_op(q, dv[i], r, {8'h00, div});
      wait_done(NBYTES);
    end
    check_done_drops();

    // back-to-back: second start presented in the done cycle
    start_op(400'h1234_5678_9ABC, 8'h10, 8'h0F, 408'h1_2345_6789_ABCF);
    wait_done(NBYTES);
    start_op(400'hFFFF, 8'h02, 8'h01, 408'h1FFFF);
    wait_done(NBYTES);
    check_done_drops();

    // start pulsed throughout RUN, operands changed at cycle 10
    start_op(400'h100, 8'h03, 8'h04, 408'h304);
    n_done = 0;
    for (int k = 1; k <= 45; k++) begin
      start = 1'b1;
      if (k == 10) begin
        multiplicand = {AW{1'b1}};
        multiplier   = 8'hFF;
        addend       = 8'h77;
      end
      @(negedge clk);
    end
    start = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (done === 1'b1) n_done++;
      @(negedge clk);
    end
    check("one_done_per_op", PW'(n_done), PW'(1));

    // reset in the middle of an operation
    start_op(rand400(), 8'hA5, 8'h3C, '0);
    repeat (20) @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrun_reset_product", product, '0);
    check("midrun_reset_busy", PW'(busy), PW'(0));
    check("midrun_reset_done", PW'(done), PW'(0));
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    start_op(400'd3, 8'd5, 8'd2, 408'd17);
    wait_done(NBYTES);
    check_done_drops();

    // zero multiplier
    start_op(rand400(), 8'h00, 8'h5A, 408'h5A);
    wait_done(ZERO_LAT);
    check_done_drops();

    repeat (3) @(negedge clk);
    check("queue_drained", PW'(exp_q.size()), PW'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/bignum_mac_400bit.md
# bignum_mac_400bit

Byte-serial multi-precision multiply-accumulate: computes `product = multiplicand * multiplier + addend` for a 400-bit multiplicand and 8-bit multiplier/addend, one byte per clock from the LSB upward. It is the reconstruction counterpart of the 400-bit by 8-bit byte-serial divider: feeding the divider's quotient, divisor and remainder back in reproduces the original dividend. It is used for result checking and for building multi-precision constants in the FPGA arithmetic path.

## Interface
- `NBYTES`, default 50: number of multiplicand bytes; multiplicand width is 8*NBYTES, product width is 8*NBYTES+8.
- `clk`: input, 1 bit. Clock, rising-edge active.
- `rst`: input, 1 bit. Reset, asynchronous, active-high.
- `start`: input, 1 bit. Request a new operation; sampled on rising `clk`.
- `multiplicand`: input, 8*NBYTES bits. Big operand; byte i is bits [8i+7:8i].
- `multiplier`: input, 8 bits. Small operand.
- `addend`: input, 8 bits. Value added to the product; the divider remainder in round-trip use.
- `product`: output, 8*NBYTES+8 bits. Result register; valid from the `done` cycle until the next accepted start.
- `busy`: output, 1 bit. High while the operation is running.
- `done`: output, 1 bit. One-cycle completion pulse.

## Operation
- States are IDLE and RUN. `done` is a registered pulse, not a state.
- Accept: when `start`=1 in IDLE, the block latches `multiplicand`, `multiplier` and `addend` into internal registers, clears `product` to 0, loads the carry register with `addend`, sets the index to 0, sets `busy`=1, sets `done`=0, and moves to RUN.
- RUN, each cycle:
  - Compute t = A[i]*M + carry as a 16-bit value. The maximum is 255*255+255 = 65280, so t never overflows.
  - Write `product[8i+7:8i]` = t[7:0] and set carry = t[15:8].
  - If i = NBYTES-1, also write `product[8*NBYTES+7:8*NBYTES]` = t[15:8], set `busy`=0, set `done`=1, and return to IDLE. Otherwise increment i.
- `start` is ignored while in RUN. Changes to the input ports after acceptance have no effect on the result.
- In IDLE with no start, `done` returns to 0 and `product` holds its value.
- A `start` in the same cycle that `done` is high is accepted normally: `done` falls and a new operation begins.
- Reset, including mid-operation: `product`=0, `busy`=0, `done`=0, state IDLE, index 0, carry 0, latched operands 0. A partial result is never exposed as valid.

## Timing
- Start is sampled at edge E0. Bytes 0..NBYTES-1 are computed on edges E1..E_NBYTES.
- `busy` is high from after E0 through E_NBYTES.
- `done` is high for exactly one cycle, from E_NBYTES to E_NBYTES+1. Latency is NBYTES cycles (50 at default).
- Back-to-back operations: a start held high at E_NBYTES+1 is accepted there. Throughput is one operation per NBYTES+1 cycles.
- `product` bytes update progressively during RUN. Consumers must qualify `product` with `done` or with `busy`=0.
- Per-cycle datapath is one 8x8 multiply plus a 16-bit add. There is no multi-cycle path.

## Configuration
- `BIGNUM_MAC_ZERO_SKIP_EN` defined:
  - If the latched `multiplier` is 0, the block skips RUN.
  - `product` = zero-extended `addend` is written at E1, `done` pulses at E1, and `busy` is high only between E0 and E1.
  - Latency is 1 cycle.
- `BIGNUM_MAC_ZERO_SKIP_EN` undefined:
  - Multiplier 0 takes the normal NBYTES-cycle path and produces the same numeric result.

## Test plan
- Minimal operands: multiplicand=1, multiplier=1, addend=0, start at E0 -> `product`=1, `busy` high for 50 cycles, `done` high only between E50 and E51.
- Full carry ripple: multiplicand=2^400-1, multiplier=0xFF, addend=0xFF -> `product[407:400]`=0xFF and `product[399:0]`=0.
- Round trip against the divider: random 400-bit dividend, divisor 7; feed the divider's quotient, 7 and the remainder -> `product[399:0]`=dividend and `product[407:400]`=0. Repeat with divisors 1, 0x80 and 0xFF.
- Start pulsed every cycle during RUN, with multiplicand/multiplier/addend changed at cycle 10 -> exactly one `done` per operation; result matches the operands latched at E0.
- Assert `rst` at cycle 20 of RUN -> `product`=0, `busy`=0 and `done`=0 immediately; a later start with 3*5+2 (multiplicand 3, multiplier 5, addend 2) gives `product`=17.
- multiplier=0, addend=0x5A -> `product`=0x5A in both builds; `done` at E50 without `BIGNUM_MAC_ZERO_SKIP_EN`, at E1 with it.
